// File: rtl/apb_arb_pkg.sv
// Shared types and sizing helpers for the round-robin APB master arbiter.
// Imported by rr_arbiter and apb_master_arbiter.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_arb_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int tmo_width(input int t);
      return $clog2(t + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr,
// wrapping modulo N. Pointer storage lives in the parent.
module rr_arbiter
   import apb_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   int c;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      c     = 0;
      for (int k = 0; k < N; k++) begin
         c = int'(ptr) + k;
         if (c >= N) c = c - N;
         if (!any && req[c]) begin
            grant[c] = 1'b1;
            idx      = IW'(c);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master sharing one completer among NUM_REQ requesters.
// Optional ACCESS-phase timeout: define APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                              pclk,
   input  logic                              presetn,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ-1:0]                req_write,
   input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]                rsp_valid,
   output logic [APB_DATA_WIDTH-1:0]         rsp_rdata,
   output logic                              rsp_err,
   output logic                              busy,
   output logic [APB_ADDR_WIDTH-1:0]         paddr,
   output logic                              pwrite,
   output logic [APB_DATA_WIDTH-1:0]         pwdata,
   output logic                              psel,
   output logic                              penable,
   input  logic [APB_DATA_WIDTH-1:0]         prdata,
   input  logic                              pready,
   input  logic                              pslverr
);

   localparam int IW = idx_width(NUM_REQ);
   localparam int AW = APB_ADDR_WIDTH;
   localparam int DW = APB_DATA_WIDTH;

   apb_arb_state_t     state_q, state_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]      gnt_q, gnt_d;
   logic [AW-1:0]      paddr_q, paddr_d;
   logic [DW-1:0]      pwdata_q, pwdata_d;
   logic               pwrite_q, pwrite_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
   logic               rsp_err_q, rsp_err_d;

   logic [NUM_REQ-1:0] arb_grant;
   logic [IW-1:0]      arb_idx;
   logic               arb_any;
   logic               tmo_hit;

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr_arbiter (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

`ifdef APB_ARB_TIMEOUT_EN
   localparam int TW = tmo_width(TIMEOUT_CYCLES);
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

   // Last ACCESS cycle allowed is the TIMEOUT_CYCLES-th; pready still wins
   assign tmo_hit = (state_q == ST_ACCESS) &&
                    (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == ST_SETUP)
         tmo_cnt_d = '0;
      else if (state_q == ST_ACCESS && !pready)
         tmo_cnt_d = tmo_cnt_q + 1'b1;
   end

   always_ff @(posedge pclk) begin
      if (!presetn) tmo_cnt_q <= '0;
      else          tmo_cnt_q <= tmo_cnt_d;
   end
`else
   localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_d       = gnt_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               paddr_d  = req_addr[arb_idx*AW +: AW];
               pwdata_d = req_wdata[arb_idx*DW +: DW];
               pwrite_d = req_write[arb_idx];
               gnt_d    = arb_idx;
               rr_ptr_d = (arb_idx == IW'(NUM_REQ - 1)) ?
                          '0 : arb_idx + 1'b1;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (pready || tmo_hit) begin
               rsp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
               rsp_err_d   = pready ? pslverr : 1'b1;
               rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         gnt_q       <= '0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE) ? arb_grant : '0;
   assign busy      = (state_q != ST_IDLE);
   assign psel      = (state_q != ST_IDLE);
   assign penable   = (state_q == ST_ACCESS);
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign pwrite    = pwrite_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
module tb_apb_master_arbiter;

   localparam int NTX = 80;

   logic         pclk = 1'b0;
   logic         presetn = 1'b0;
   logic [3:0]   req_valid = '0;
   logic [3:0]   req_ready;
   logic [3:0]   req_write = '0;
   logic [127:0] req_addr = '0;
   logic [127:0] req_wdata = '0;
   logic [3:0]   rsp_valid;
   logic [31:0]  rsp_rdata;
   logic         rsp_err;
   logic         busy;
   logic [31:0]  paddr;
   logic         pwrite;
   logic [31:0]  pwdata;
   logic         psel;
   logic         penable;
   logic [31:0]  prdata = '0;
   logic         pready = 1'b0;
   logic         pslverr = 1'b0;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   int cmp_wait = 0;
   bit cmp_never = 1'b0;
   int acc_cnt = 0;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   apb_master_arbiter #(
      .NUM_REQ(4), .APB_ADDR_WIDTH(32),
      .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
   ) dut (
      .pclk(pclk), .presetn(presetn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .busy(busy), .paddr(paddr), .pwrite(pwrite),
      .pwdata(pwdata), .psel(psel), .penable(penable),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc++;

   function automatic logic [31:0] cmp_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_5A5A);
   endfunction

   // Completer: answers in ACCESS cycle cmp_wait+1, noise elsewhere
   always @(negedge pclk) begin
      if (psel && penable) begin
         acc_cnt++;
         if (!cmp_never && acc_cnt == cmp_wait + 1) begin
            pready  = 1'b1;
            pslverr = (paddr == 32'h100);
            prdata  = pslverr ? 32'h0 :
                      (pwrite ? $urandom : cmp_rd(paddr));
            if (pwrite && !pslverr) mem[paddr] = pwdata;
         end else begin
            pready  = 1'b0;
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
         end
      end else begin
         acc_cnt = 0;
         pready  = 1'($urandom_range(0, 1));
         pslverr = 1'($urandom_range(0, 1));
         prdata  = $urandom;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      req_valid = '0;
      req_write = '0;
      cmp_never = 1'b0;
      cmp_wait  = 0;
      presetn   = 1'b0;
      repeat (2) @(negedge pclk);
      presetn = 1'b1;
   endtask

   task automatic drive_req(input int r, input bit wr,
                            input logic [31:0] a,
                            input logic [31:0] d);
      req_write[r]         = wr;
      req_addr[r*32 +: 32]  = a;
      req_wdata[r*32 +: 32] = d;
      req_valid[r]         = 1'b1;
   endtask

   task automatic wait_rsp(output bit seen);
      seen = 1'b0;
      @(negedge pclk);
      req_valid = '0;
      for (int j = 0; j < 40; j++) begin
         @(negedge pclk);
         if (rsp_valid != 0) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_chk++;
      if ({psel, penable, pwrite, busy, rsp_err, rsp_valid, req_ready}
          !== 15'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl got=%b exp=0",
            {psel, penable, pwrite, busy, rsp_err, rsp_valid, req_ready});
      end
      n_chk++;
      if ({paddr, pwdata, rsp_rdata} !== 96'b0) begin
         n_fail++;
         $display("FAIL reset_data paddr=%h pwdata=%h rdata=%h exp=0",
            paddr, pwdata, rsp_rdata);
      end
   endtask

   task automatic test_single_write();
      apply_reset();
      cmp_wait = 1;
      drive_req(0, 1'b1, 32'h4, 32'hDEAD_BEEF);
      #1;
      n_chk++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL wr_ready got=%b exp=0001", req_ready);
      end
      @(negedge pclk);
      req_valid = '0;
      n_chk++;
      if ({psel, penable, pwrite, paddr, pwdata} !==
          {3'b101, 32'h4, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL wr_setup got=%b%b%b %h %h exp=101 4 deadbeef",
            psel, penable, pwrite, paddr, pwdata);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge pclk);
         n_chk++;
         if ({psel, penable, pwrite, paddr, pwdata, rsp_valid} !==
             {3'b111, 32'h4, 32'hDEAD_BEEF, 4'b0}) begin
            n_fail++;
            $display("FAIL wr_access%0d got=%b%b%b %h %h %b", k,
               psel, penable, pwrite, paddr, pwdata, rsp_valid);
         end
      end
      @(negedge pclk);
      n_chk++;
      if ({rsp_valid, rsp_err, rsp_rdata, psel} !==
          {4'b0001, 1'b0, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL wr_rsp got v=%b e=%b d=%h psel=%b exp 0001 0 0 0",
            rsp_valid, rsp_err, rsp_rdata, psel);
      end
   endtask

   task automatic test_read_back();
      apply_reset();
      cmp_wait = 0;
      drive_req(2, 1'b0, 32'h4, 32'h0);
      #1;
      n_chk++;
      if (req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL rd_ready got=%b exp=0100", req_ready);
      end
      @(negedge pclk);
      req_valid = '0;
      @(negedge pclk);
      n_chk++;
      if ({psel, penable, pwrite, paddr} !== {3'b110, 32'h4}) begin
         n_fail++;
         $display("FAIL rd_access got=%b%b%b %h exp=110 4",
            psel, penable, pwrite, paddr);
      end
      @(negedge pclk);
      n_chk++;
      if ({rsp_valid, rsp_err, rsp_rdata} !==
          {4'b0100, 1'b0, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL rd_rsp got v=%b e=%b d=%h exp 0100 0 deadbeef",
            rsp_valid, rsp_err, rsp_rdata);
      end
   endtask

   task automatic test_fairness();
      bit found;
      apply_reset();
      for (int r = 0; r < 4; r++)
         drive_req(r, 1'b0, 32'h200 + 32'(4 * r), 32'h0);
      #1;
      for (int k = 0; k < 6; k++) begin
         found = 1'b0;
         for (int j = 0; j < 20 && !found; j++) begin
            if (req_ready != 0) found = 1'b1;
            else @(negedge pclk);
         end
         n_chk++;
         if (!found || req_ready !== (4'b0001 << (k % 4)) || psel) begin
            n_fail++;
            $display("FAIL fair_grant%0d got=%b psel=%b exp=%b psel=0",
               k, req_ready, psel, 4'b0001 << (k % 4));
         end
         @(negedge pclk);
      end
      req_valid = '0;
      repeat (6) @(negedge pclk);
   endtask

   task automatic test_slave_error();
      bit seen;
      apply_reset();
      drive_req(1, 1'b0, 32'h100, 32'h0);
      wait_rsp(seen);
      n_chk++;
      if (!seen || {rsp_valid, rsp_err, rsp_rdata} !==
          {4'b0010, 1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL slverr_rsp got v=%b e=%b d=%h exp 0010 1 0",
            rsp_valid, rsp_err, rsp_rdata);
      end
      drive_req(3, 1'b0, 32'h4, 32'h0);
      wait_rsp(seen);
      n_chk++;
      if (!seen || {rsp_valid, rsp_err, rsp_rdata} !==
          {4'b1000, 1'b0, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL slverr_next got v=%b e=%b d=%h exp 1000 0 deadbeef",
            rsp_valid, rsp_err, rsp_rdata);
      end
   endtask

   task automatic test_timeout();
      int  n_acc;
      bit  seen;
      apply_reset();
      cmp_never = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
      for (int t = 0; t < 2; t++) begin
         cmp_never = (t == 0);
         cmp_wait  = 7;
         drive_req(0, 1'b0, 32'h4, 32'h0);
         @(negedge pclk);
         req_valid = '0;
         n_acc = 0;
         seen  = 1'b0;
         for (int j = 0; j < 40 && !seen; j++) begin
            @(negedge pclk);
            if (rsp_valid != 0) seen = 1'b1;
            else if (psel && penable) n_acc++;
         end
         n_chk++;
         if (!seen || n_acc != 8 || rsp_valid !== 4'b0001 ||
             rsp_err !== (t == 0) ||
             rsp_rdata !== ((t == 0) ? 32'h0 : 32'hDEAD_BEEF)) begin
            n_fail++;
            $display("FAIL timeout%0d acc=%0d v=%b e=%b d=%h exp acc=8",
               t, n_acc, rsp_valid, rsp_err, rsp_rdata);
         end
      end
`else
      drive_req(0, 1'b0, 32'h4, 32'h0);
      @(negedge pclk);
      req_valid = '0;
      n_acc = 0;
      seen  = 1'b0;
      for (int j = 0; j < 100; j++) begin
         @(negedge pclk);
         if (rsp_valid != 0) seen = 1'b1;
         if (psel && penable) n_acc++;
      end
      n_chk++;
      if (seen || n_acc != 100) begin
         n_fail++;
         $display("FAIL no_timeout acc=%0d rsp_seen=%b exp 100 0",
            n_acc, seen);
      end
`endif
   endtask

   task automatic test_reset_access();
      int bad;
      bit seen;
      apply_reset();
      cmp_never = 1'b1;
      drive_req(2, 1'b0, 32'h4, 32'h0);
      @(negedge pclk);
      req_valid = '0;
      repeat (2) @(negedge pclk);
      n_chk++;
      if (!(psel && penable)) begin
         n_fail++;
         $display("FAIL rst_pre psel=%b penable=%b exp 1 1", psel, penable);
      end
      presetn = 1'b0;
      @(negedge pclk);
      n_chk++;
      if ({psel, penable, busy, rsp_valid} !== 7'b0) begin
         n_fail++;
         $display("FAIL rst_abort got=%b exp=0",
            {psel, penable, busy, rsp_valid});
      end
      presetn   = 1'b1;
      cmp_never = 1'b0;
      bad = 0;
      repeat (4) begin
         @(negedge pclk);
         if (rsp_valid != 0 || psel) bad++;
      end
      n_chk++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL rst_quiet bad_cycles=%0d exp=0", bad);
      end
      for (int r = 0; r < 4; r++)
         drive_req(r, 1'b0, 32'h200 + 32'(4 * r), 32'h0);
      #1;
      n_chk++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL rst_first got=%b exp=0001", req_ready);
      end
      wait_rsp(seen);
      n_chk++;
      if (!seen || rsp_valid !== 4'b0001) begin
         n_fail++;
         $display("FAIL rst_first_rsp got=%b exp=0001", rsp_valid);
      end
   endtask

   task automatic test_random();
      int ptr_m, done, launched, exp_cyc, g_exp, w, g;
      bit have, wr, e_err;
      logic [3:0] drop, er, exp_ready;
      logic [31:0] a, d, e_data;
      bit p_wr [4];
      logic [31:0] p_a [4];
      logic [31:0] p_d [4];
      apply_reset();
      ptr_m = 0; done = 0; launched = 0; exp_cyc = 0;
      g_exp = 0; have = 1'b0; drop = '0;
      e_err = 1'b0; e_data = '0;
      for (int b = 0; b < 3000 && done < NTX; b++) begin
         @(negedge pclk);
         req_valid = req_valid & ~drop;
         drop = '0;
         for (int r = 0; r < 4; r++) begin
            if (!req_valid[r] && launched < NTX &&
                $urandom_range(0, 2) == 0) begin
               wr = 1'($urandom_range(0, 1));
               a  = ($urandom_range(0, 7) == 0) ? 32'h100 :
                    32'h200 + 32'(4 * $urandom_range(0, 7));
               d  = $urandom;
               p_wr[r] = wr; p_a[r] = a; p_d[r] = d;
               drive_req(r, wr, a, d);
               launched++;
            end
         end
         #1;
         er = (have && cyc == exp_cyc) ? (4'b0001 << g_exp) : 4'b0;
         n_chk++;
         if (rsp_valid !== er) begin
            n_fail++;
            $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b",
               cyc, rsp_valid, er);
         end
         if (er != 0) begin
            have = 1'b0;
            done++;
            n_chk++;
            if ({rsp_err, rsp_rdata} !== {e_err, e_data}) begin
               n_fail++;
               $display("FAIL rnd_rsp_data cyc=%0d got=%b %h exp=%b %h",
                  cyc, rsp_err, rsp_rdata, e_err, e_data);
            end
         end
         exp_ready = '0;
         g = 0;
         if (!have) begin
            for (int k = 3; k >= 0; k--) begin
               if (req_valid[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
            end
            if (req_valid != 0) exp_ready[g] = 1'b1;
         end
         n_chk++;
         if (req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL rnd_ready cyc=%0d got=%b exp=%b",
               cyc, req_ready, exp_ready);
         end
         if (exp_ready != 0) begin
            g_exp   = g;
            ptr_m   = (g + 1) % 4;
            w       = $urandom_range(0, 3);
            cmp_wait = w;
            exp_cyc = cyc + 3 + w;
            have    = 1'b1;
            drop[g] = 1'b1;
            if (p_a[g] == 32'h100) begin
               e_err = 1'b1; e_data = '0;
            end else if (p_wr[g]) begin
               e_err = 1'b0; e_data = '0;
               ref_mem[p_a[g]] = p_d[g];
            end else begin
               e_err  = 1'b0;
               e_data = ref_mem.exists(p_a[g]) ? ref_mem[p_a[g]] :
                        (p_a[g] ^ 32'h5A5A_5A5A);
            end
         end
      end
      req_valid = '0;
      n_chk++;
      if (done != NTX) begin
         n_fail++;
         $display("FAIL rnd_complete done=%0d exp=%0d", done, NTX);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_back();
      test_fairness();
      test_slave_error();
      test_timeout();
      test_reset_access();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
         n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Round-robin APB master that shares one APB completer (typically a bank of configuration registers) among up to `NUM_REQ` internal requesters, such as the boot loader, the management CPU bridge and MAC/PHY status engines. Each requester issues single read or write transactions over a valid/ready request port. The block sequences the APB SETUP and ACCESS phases, waits for `pready`, and returns read data and error status to the granted requester. It sits between the requesters and the configuration register bank on the `pclk` domain.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `APB_ADDR_WIDTH`, default 32: address width.
- `APB_DATA_WIDTH`, default 32: data width.
- `TIMEOUT_CYCLES`, default 64: maximum number of ACCESS cycles before abort. Used only with the timeout macro.

Ports:
- `pclk`  in  1  clock; all logic on its rising edge.
- `presetn`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  one-hot accept pulse.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*APB_ADDR_WIDTH  flattened addresses; requester i occupies slice i.
- `req_wdata`  in  NUM_REQ*APB_DATA_WIDTH  flattened write data.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `rsp_rdata`  out  APB_DATA_WIDTH  read data; valid with `rsp_valid`.
- `rsp_err`  out  1  slave error or timeout; valid with `rsp_valid`.
- `busy`  out  1  high in every state other than IDLE.
- `paddr`, `pwrite`, `pwdata`  out  addr/1/data  APB request fields.
- `psel`, `penable`  out  1  APB control.
- `prdata`  in  APB_DATA_WIDTH; `pready`, `pslverr`  in  1  APB completion.

## Operation
The FSM has three states: IDLE, SETUP and ACCESS.
- **IDLE:** the arbiter picks the first `req_valid` at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - `req_ready[g]` is combinational and equals (state==IDLE) && grant[g].
  - On accept, the block registers addr, wdata and write into `paddr`, `pwdata` and `pwrite`, stores g, sets `rr_ptr` to (g+1) mod `NUM_REQ`, and moves to SETUP.
- **SETUP:** `psel`=1, `penable`=0 for exactly one cycle, then the FSM moves to ACCESS.
- **ACCESS:** `psel`=1 and `penable`=1, held until `pready`=1.
  - On that edge the block registers `rsp_rdata` = `prdata` for reads, or 0 for writes.
  - It also registers `rsp_err` = `pslverr`, pulses `rsp_valid[g]` for the following cycle, drops `psel` and `penable`, and returns to IDLE.
- Requesters hold `req_*` stable while `req_valid` is high until `req_ready`. Only one transfer is outstanding at a time.
- A requester may present a new request in the cycle that its `rsp_valid` is high. It competes normally; the round-robin pointer already favours the others.
- `pwdata`, `paddr` and `pwrite` are stable from SETUP through the end of ACCESS. `pwdata` is don't-care for reads but is still driven from the captured value.
- Simultaneous requests are handled as follows:
  - Exactly one grant is issued per IDLE cycle.
  - Requests that are not granted remain pending, with no `req_ready`.
  - A requester that drops `req_valid` before being accepted is ignored.

## Timing
- Reset state, asserted at the first `pclk` edge with `presetn`=0:
  - FSM goes to IDLE and `rr_ptr`=0.
  - `psel`, `penable`, `pwrite`, `busy` = 0.
  - `paddr`, `pwdata`, `rsp_rdata` = 0.
  - `rsp_valid` = 0 and `rsp_err` = 0.
- Accept in cycle T leads to SETUP at T+1 and ACCESS at T+2.
- With a zero-wait completer (`pready` in the first ACCESS cycle), `rsp_valid` is at T+3.
- With the registered-`pready` config bank (`pready` in the second ACCESS cycle), `rsp_valid` is at T+4.
- At least one `psel`=0 cycle always occurs between transfers, because IDLE lasts a minimum of one cycle.
- Reset mid-transfer aborts the transfer. `psel` drops at the reset edge, no `rsp_valid` is issued, and the requester must re-issue after reset.
- `pready` or `pslverr` outside ACCESS is ignored.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - A counter of `$clog2(TIMEOUT_CYCLES+1)` bits clears on entry to ACCESS and increments each ACCESS cycle without `pready`.
  - When it reaches `TIMEOUT_CYCLES`, the transfer ends: `psel`/`penable` drop, `rsp_valid[g]` pulses next cycle with `rsp_err`=1 and `rsp_rdata`=0, and the FSM returns to IDLE.
  - If `pready` arrives in the same cycle as the timeout, `pready` wins and the transfer completes normally.
- `APB_ARB_TIMEOUT_EN` undefined: ACCESS waits indefinitely. No counter logic is present, and `TIMEOUT_CYCLES` is unused.

## Structure
- Package `apb_arb_pkg` contains:
  - the FSM state enum `apb_arb_state_t` (IDLE, SETUP, ACCESS);
  - the localparam function for requester-index width, `$clog2(NUM_REQ)`;
  - the timeout counter width helper.
- Sub-module `rr_arbiter`: pure combinational. Inputs are `req` and `ptr`; outputs are the one-hot `grant`, the grant index and `any`. Pointer storage stays in the parent.

## Test plan
- **Single write:** req0 writes addr 0x0000_0004, data 0xDEAD_BEEF; the bench completer drives `pready` on the 2nd ACCESS cycle. Required response: one SETUP and two ACCESS cycles with stable fields, then `rsp_valid`=4'b0001 at T+4, `rsp_err`=0.
- **Read back:** req2 reads 0x0000_0004. Required response: `rsp_rdata`=0xDEAD_BEEF and `rsp_valid`=4'b0100.
- **Fairness:** all four requesters hold `req_valid` continuously. Required response: grant order 0,1,2,3,0,1 with exactly one `req_ready` per IDLE, and `psel` low for at least one cycle between transfers.
- **Slave error:** the completer answers 0x0000_0100 with `pslverr`=1. Required response: `rsp_err`=1, `rsp_rdata`=0, and the next transfer is unaffected.
- **Timeout:** with `APB_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, `pready` is never asserted. Required response: ACCESS lasts 8 cycles, then `rsp_valid` with `rsp_err`=1.
  - A second case asserts `pready` exactly in cycle 8. Required response: normal completion with `rsp_err`=0.
- **Reset in ACCESS:** `presetn`=0 for one edge. Required response: `psel`=0, `busy`=0, no `rsp_valid`, `rr_ptr`=0, so req0 wins first after reset when all requesters request.
